// File: rtl/l3_maxpool.sv
// l3_maxpool: 2x2 pooling stage between the layer-2 conv read stream and the
// layer-3 engine. Every 4 accepted samples form one window of one channel.
// The window is reduced to a single value, right-shifted by SHIFT, saturated
// to DOUT_W bits, tagged with its channel and pushed into a show-ahead FIFO.
// frame_done pulses once after the NUM_WIN-th window of a frame is pushed.
//
// Build option: define L3_POOL_AVG_EN for average pooling (truncating sum/4)
// instead of the default max pooling. Ports and timing are the same in both.
module l3_maxpool #(
    parameter int DIN_W      = 18,
    parameter int DOUT_W     = 9,
    parameter int SHIFT      = 4,
    parameter int NUM_CH     = 4,
    parameter int NUM_WIN    = 100,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_done,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  logic [DIN_W-1:0]              din,
    output logic                          out_vld,
    output logic [DOUT_W-1:0]             out_data,
    output logic [1:0]                    out_ch,
    input  logic                          out_rd,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WIN_W = $clog2(NUM_WIN + 1);
    localparam int ENT_W = DOUT_W + 2;
`ifdef L3_POOL_AVG_EN
    localparam int ACC_W = DIN_W + 2;
`else
    localparam int ACC_W = DIN_W;
`endif
    localparam logic [DIN_W-1:0] SAT_MAX = DIN_W'((1 << DOUT_W) - 1);

    typedef enum logic {S_ACC, S_PUSH} state_e;

    state_e               state_q, state_d;
    logic [1:0]           samp_cnt_q, samp_cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [DIN_W-1:0]     res_q, res_d;
    logic [1:0]           ch_q, ch_d;
    logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
    logic                 frame_done_q, frame_done_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];

    logic                 clear;
    logic                 push_pend;
    logic                 accept;
    logic                 pop;
    logic [ACC_W-1:0]     din_ext;
    logic [ACC_W-1:0]     acc_nx;
    logic [DIN_W-1:0]     res_fin;
    logic [DIN_W-1:0]     shifted;
    logic [DOUT_W-1:0]    sat_val;
    logic [ENT_W-1:0]     wr_entry;

    // tx_done aborts the frame exactly like a reset
    assign clear     = rst | tx_done;
    // the PUSH cycle is the one cycle a finished window is waiting to be written
    assign push_pend = (state_q == S_PUSH);
    // a pending push already owns a FIFO slot, so count it before accepting more
    assign in_rdy    = ((CNT_W + 1)'(cnt_q) + (CNT_W + 1)'(push_pend)) < (CNT_W + 1)'(FIFO_DEPTH);
    assign accept    = in_vld && in_rdy;
    assign pop       = out_rd && (cnt_q != '0);

    assign out_vld    = (cnt_q != '0);
    assign out_data   = mem_q[rd_ptr_q][DOUT_W-1:0];
    assign out_ch     = mem_q[rd_ptr_q][ENT_W-1:DOUT_W];
    assign frame_done = frame_done_q;
    assign fifo_cnt   = cnt_q;

    // window reduction step: running max, or running sum in the averaging build
    always_comb begin
        din_ext = ACC_W'(din);
`ifdef L3_POOL_AVG_EN
        acc_nx  = acc_q + din_ext;
        res_fin = DIN_W'(acc_nx >> 2);
`else
        acc_nx  = (din_ext > acc_q) ? din_ext : acc_q;
        res_fin = acc_nx;
`endif
    end

    // requantise the finished window: shift, then clamp to the output range
    always_comb begin
        shifted  = res_q >> SHIFT;
        sat_val  = (shifted > SAT_MAX) ? DOUT_W'(SAT_MAX) : shifted[DOUT_W-1:0];
        wr_entry = {ch_q, sat_val};
    end

    // next state for the window FSM, channel/frame counters and FIFO pointers
    always_comb begin
        state_d      = S_ACC;
        samp_cnt_d   = samp_cnt_q;
        acc_d        = acc_q;
        res_d        = res_q;
        ch_d         = ch_q;
        win_cnt_d    = win_cnt_q;
        frame_done_d = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;

        // samples are taken in both states; in PUSH samp_cnt is already 0
        if (accept) begin
            samp_cnt_d = samp_cnt_q + 2'd1;
            unique case (samp_cnt_q)
                2'd0:       acc_d = din_ext;
                2'd1, 2'd2: acc_d = acc_nx;
                default: begin
                    res_d   = res_fin;
                    state_d = S_PUSH;
                end
            endcase
        end

        if (push_pend) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (win_cnt_q == WIN_W'(NUM_WIN - 1)) begin
                win_cnt_d    = '0;
                ch_d         = '0;
                frame_done_d = 1'b1;
            end else begin
                win_cnt_d = win_cnt_q + 1'b1;
                ch_d      = (ch_q == 2'(NUM_CH - 1)) ? 2'd0 : ch_q + 2'd1;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        cnt_d = cnt_q + CNT_W'(push_pend) - CNT_W'(pop);
    end

    // control and datapath registers
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= S_ACC;
            samp_cnt_q   <= '0;
            acc_q        <= '0;
            res_q        <= '0;
            ch_q         <= '0;
            win_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            samp_cnt_q   <= samp_cnt_d;
            acc_q        <= acc_d;
            res_q        <= res_d;
            ch_q         <= ch_d;
            win_cnt_q    <= win_cnt_d;
            frame_done_q <= frame_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    // FIFO storage; cleared so the head reads as zero straight after reset
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_pend) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_l3_maxpool.sv
// Bench for l3_maxpool: a queue-based reference model updated on every rising
// edge, a compare process on every falling edge, directed literal checks
// for the documented scenarios, and a randomized traffic phase.
module tb_l3_maxpool;

    localparam int DIN_W      = 18;
    localparam int DOUT_W     = 9;
    localparam int SHIFT      = 4;
    localparam int NUM_CH     = 4;
    localparam int NUM_WIN    = 100;
    localparam int FIFO_DEPTH = 8;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          tx_done = 1'b0;
    logic                          in_vld = 1'b0;
    logic                          in_rdy;
    logic [DIN_W-1:0]              din = '0;
    logic                          out_vld;
    logic [DOUT_W-1:0]             out_data;
    logic [1:0]                    out_ch;
    logic                          out_rd = 1'b0;
    logic                          frame_done;
    logic [$clog2(FIFO_DEPTH):0]   fifo_cnt;

    l3_maxpool #(
        .DIN_W(DIN_W), .DOUT_W(DOUT_W), .SHIFT(SHIFT),
        .NUM_CH(NUM_CH), .NUM_WIN(NUM_WIN), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .tx_done(tx_done),
        .in_vld(in_vld), .in_rdy(in_rdy), .din(din),
        .out_vld(out_vld), .out_data(out_data), .out_ch(out_ch), .out_rd(out_rd),
        .frame_done(frame_done), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct { int d; int c; } ent_t;
    ent_t mq[$];
    int   win_s[$];
    ent_t pend_e;
    bit   pend   = 0;
    int   m_ch   = 0;
    int   m_win  = 0;
    bit   fd_exp = 0;
    bit   chk_en = 0;
    int   fd_seen = 0;

    function automatic int pool4(input int a, input int b, input int c, input int d);
        int v;
`ifdef L3_POOL_AVG_EN
        v = (a + b + c + d) / 4;
`else
        v = a;
        if (b > v) v = b;
        if (c > v) v = c;
        if (d > v) v = d;
`endif
        v = v >> SHIFT;
        if (v > (1 << DOUT_W) - 1) v = (1 << DOUT_W) - 1;
        return v;
    endfunction

    always @(posedge clk) begin
        bit   acc_ok;
        ent_t tmp;
        if (rst || tx_done) begin
            mq.delete(); win_s.delete();
            pend = 0; m_ch = 0; m_win = 0; fd_exp = 0;
        end else begin
            acc_ok = in_vld && ((mq.size() + pend) < FIFO_DEPTH);
            fd_exp = 0;
            if (out_rd && mq.size() > 0) tmp = mq.pop_front();
            if (pend) begin
                mq.push_back(pend_e);
                m_win++;
                if (m_win == NUM_WIN) begin
                    fd_exp = 1; m_win = 0; m_ch = 0;
                end else begin
                    m_ch = (m_ch + 1) % NUM_CH;
                end
                pend = 0;
            end
            if (acc_ok) begin
                win_s.push_back(int'(din));
                if (win_s.size() == 4) begin
                    pend_e.d = pool4(win_s[0], win_s[1], win_s[2], win_s[3]);
                    pend_e.c = m_ch;
                    pend = 1;
                    win_s.delete();
                end
            end
        end
    end

    // compare DUT against the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_vld", int'(out_vld), int'(mq.size() != 0));
            chk("fifo_cnt", int'(fifo_cnt), mq.size());
            chk("in_rdy", int'(in_rdy), int'((mq.size() + pend) < FIFO_DEPTH));
            chk("frame_done", int'(frame_done), int'(fd_exp));
            if (mq.size() != 0) begin
                chk("out_data", int'(out_data), mq[0].d);
                chk("out_ch", int'(out_ch), mq[0].c);
            end
            if (frame_done) fd_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input logic [DIN_W-1:0] v);
        bit ok = 0;
        in_vld = 1'b1; din = v;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = in_rdy;
            @(posedge clk); #1;
        end
        in_vld = 1'b0;
        chk("send_accept", int'(ok), 1);
    endtask

    task automatic abort();
        tx_done = 1'b1; cyc(1); tx_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        bit ok;
        cyc(2);
        rst = 1'b0;
        chk_en = 1;
        // reset values
        chk("rst_out_vld", int'(out_vld), 0);
        chk("rst_in_rdy", int'(in_rdy), 1);
        chk("rst_fifo_cnt", int'(fifo_cnt), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_frame_done", int'(frame_done), 0);

        // max + requantisation with two-cycle visibility
        send(16); send(80); send(48); send(32);
        chk("lat_not_yet", int'(out_vld), 0);
        cyc(1);
        chk("lat_out_vld", int'(out_vld), 1);
        chk("lat_out_data", int'(out_data), 5);
        chk("lat_out_ch", int'(out_ch), 0);
        out_rd = 1'b1; cyc(1); out_rd = 1'b0;
        chk("pop_empty", int'(out_vld), 0);

        // saturation and channel rotation
        abort();
        for (int w = 0; w < 5; w++) begin
            send(0); send(0); send(0); send(18'h3FFFF);
        end
        cyc(2);
        for (int w = 0; w < 5; w++) begin
            chk("sat_data", int'(out_data), 511);
            chk("sat_ch", int'(out_ch), w % 4);
            out_rd = 1'b1; cyc(1); out_rd = 1'b0;
        end

        // back-pressure
        abort();
        for (int i = 0; i < 32; i++) send(DIN_W'($urandom));
        chk("bp_rdy_low", int'(in_rdy), 0);
        cyc(1);
        chk("bp_full", int'(fifo_cnt), 8);
        in_vld = 1'b1; din = 18'd77;
        cyc(2);
        chk("bp_no_ovf", int'(fifo_cnt), 8);
        out_rd = 1'b1; cyc(1); out_rd = 1'b0;
        chk("bp_rdy_back", int'(in_rdy), 1);
        chk("bp_cnt_7", int'(fifo_cnt), 7);
        cyc(1);
        in_vld = 1'b0;
        out_rd = 1'b1;
        for (int i = 0; i < 7; i++) send(DIN_W'($urandom));
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = (fifo_cnt == 0) && (mq.size() == 0) && !pend;
            cyc(1);
        end
        chk("bp_drained", int'(ok), 1);
        cyc(3);
        chk("rd_on_empty", int'(fifo_cnt), 0);
        out_rd = 1'b0;

        // full frame
        abort();
        fd0 = fd_seen;
        out_rd = 1'b1;
        for (int i = 0; i < 4 * NUM_WIN; i++) send(DIN_W'($urandom));
        cyc(5);
        out_rd = 1'b0;
        chk("frame_pulses", fd_seen - fd0, 1);
        send(1); send(2); send(3); send(4);
        cyc(1);
        chk("frame_next_ch", int'(out_ch), 0);
        chk("frame_next_vld", int'(out_vld), 1);
        out_rd = 1'b1; cyc(1); out_rd = 1'b0;

        // mid-window abort
        abort();
        send(500); send(600);
        abort();
        send(7); send(9); send(3); send(1);
        cyc(1);
        chk("abort_vld", int'(out_vld), 1);
        chk("abort_data", int'(out_data), 0);
        chk("abort_ch", int'(out_ch), 0);
        out_rd = 1'b1; cyc(1); out_rd = 1'b0;
        send(100); send(200); send(300); send(400);
        cyc(1);
`ifdef L3_POOL_AVG_EN
        chk("pool_data", int'(out_data), 15);
`else
        chk("pool_data", int'(out_data), 25);
`endif
        chk("pool_ch", int'(out_ch), 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            in_vld  = ($urandom_range(3) != 0);
            din     = ($urandom_range(7) == 0) ? DIN_W'($urandom) : DIN_W'($urandom_range(2000));
            out_rd  = ($urandom_range(2) == 0);
            tx_done = ($urandom_range(150) == 0);
            cyc(1);
        end
        in_vld = 1'b0; tx_done = 1'b0; out_rd = 1'b1;
        cyc(20);
        chk("final_empty", int'(fifo_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
